// File: rtl/global_param.sv
// rtl/global_param.sv - shared destination encodings, PSW bit indices and writeback entry type
package global_param;

   typedef enum logic [1:0] {
      DST_NONE = 2'b00,
      DST_ACC  = 2'b01,
      DST_B    = 2'b10,
      DST_DIR  = 2'b11
   } dst_e;

   localparam int PSW_CY = 7;
   localparam int PSW_AC = 6;
   localparam int PSW_OV = 2;
   localparam int PSW_P  = 0;

   // Positions inside the {cy,ac,ov} flag update mask
   localparam int MASK_CY = 2;
   localparam int MASK_AC = 1;
   localparam int MASK_OV = 0;

   typedef struct packed {
      logic [7:0] data;
      dst_e       dst;
      logic [7:0] addr;
   } wb_entry_t;

   function automatic logic dst_is_mem(input logic [1:0] sel);
      return (dst_e'(sel) == DST_B) || (dst_e'(sel) == DST_DIR);
   endfunction

endpackage

// File: rtl/mc8051_wb_fifo2.sv
// rtl/mc8051_wb_fifo2.sv - two-entry in-order writeback queue with valid/ready on both sides
module mc8051_wb_fifo2
   import global_param::*;
(
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      push_i,
   input  wb_entry_t push_data_i,
   output logic      full_o,
   input  logic      pop_i,
   output logic      vld_o,
   output wb_entry_t head_o
);

   wb_entry_t  slot0_q, slot0_d;
   wb_entry_t  slot1_q, slot1_d;
   logic [1:0] count_q, count_d;
   logic       push_ok, pop_ok;

   assign full_o  = (count_q == 2'd2);
   assign vld_o   = (count_q != 2'd0);
   assign head_o  = slot0_q;
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && vld_o;

   // slot0 is always the head; a pop with one entry and a push refills it directly
   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      count_d = count_q;
      case (count_q)
         2'd0: begin
            if (push_ok) begin
               slot0_d = push_data_i;
               count_d = 2'd1;
            end
         end
         2'd1: begin
            if (push_ok && pop_ok) begin
               slot0_d = push_data_i;
            end else if (push_ok) begin
               slot1_d = push_data_i;
               count_d = 2'd2;
            end else if (pop_ok) begin
               count_d = 2'd0;
            end
         end
         2'd2: begin
            if (pop_ok) begin
               slot0_d = slot1_q;
               count_d = 2'd1;
            end
         end
         default: count_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= 2'd0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/mc8051_alu_wb.sv
// rtl/mc8051_alu_wb.sv - 8051 ALU writeback stage: ACC/PSW update and memory writeback queue
// Optional MC8051_WB_BYPASS_EN: empty-queue results go straight to the writeback port.
module mc8051_alu_wb
   import global_param::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_alu_vld,
   output logic       o_alu_rdy,
   input  logic [7:0] i_alu_res,
   input  logic [1:0] i_dst_sel,
   input  logic [7:0] i_dst_addr,
   input  logic       i_cy,
   input  logic       i_ac,
   input  logic       i_ov,
   input  logic [2:0] i_flag_mask,
   input  logic       i_psw_bit_we,
   input  logic [2:0] i_psw_bit_sel,
   input  logic       i_psw_bit_val,
   input  logic       i_sfr_psw_we,
   input  logic [7:0] i_sfr_psw_wdata,
   input  logic       i_sfr_acc_we,
   input  logic [7:0] i_sfr_acc_wdata,
   output logic       o_wb_vld,
   input  logic       i_wb_rdy,
   output logic [7:0] o_wb_data,
   output logic [1:0] o_wb_dst,
   output logic [7:0] o_wb_addr,
   output logic [7:0] o_acc,
   output logic [7:0] o_psw,
   output logic       o_cy
);

   logic      accept, to_mem, bypass, push;
   logic      fifo_full, fifo_vld;
   wb_entry_t in_entry, head_entry, out_entry;
   logic [7:0] acc_q, acc_d;
   logic [7:0] psw_q, psw_d;

   assign o_alu_rdy = !fifo_full;
   assign accept    = i_alu_vld && o_alu_rdy;
   assign to_mem    = accept && dst_is_mem(i_dst_sel);
   assign in_entry  = '{data: i_alu_res, dst: dst_e'(i_dst_sel), addr: i_dst_addr};

`ifdef MC8051_WB_BYPASS_EN
   assign bypass = to_mem && !fifo_vld && i_wb_rdy;
`else
   assign bypass = 1'b0;
`endif

   assign push = to_mem && !bypass;

   mc8051_wb_fifo2 u_wb_fifo (
      .clk_i       (i_clk),
      .rst_ni      (i_rst_n),
      .push_i      (push),
      .push_data_i (in_entry),
      .full_o      (fifo_full),
      .pop_i       (i_wb_rdy),
      .vld_o       (fifo_vld),
      .head_o      (head_entry)
   );

   // Payload reads as zero whenever nothing is being offered
   always_comb begin
      out_entry = '0;
      if (fifo_vld) begin
         out_entry = head_entry;
      end else if (bypass) begin
         out_entry = in_entry;
      end
   end

   assign o_wb_vld  = fifo_vld || bypass;
   assign o_wb_data = out_entry.data;
   assign o_wb_dst  = out_entry.dst;
   assign o_wb_addr = out_entry.addr;

   always_comb begin
      acc_d = acc_q;
      if (i_sfr_acc_we) begin
         acc_d = i_sfr_acc_wdata;
      end
      if (accept && (dst_e'(i_dst_sel) == DST_ACC)) begin
         acc_d = i_alu_res;
      end
   end

   // Later assignments win: SFR byte < single bit < masked ALU flag; parity tracks acc_d
   always_comb begin
      psw_d = psw_q;
      if (i_sfr_psw_we) begin
         psw_d = i_sfr_psw_wdata;
      end
      if (i_psw_bit_we) begin
         psw_d[i_psw_bit_sel] = i_psw_bit_val;
      end
      if (accept) begin
         if (i_flag_mask[MASK_CY]) psw_d[PSW_CY] = i_cy;
         if (i_flag_mask[MASK_AC]) psw_d[PSW_AC] = i_ac;
         if (i_flag_mask[MASK_OV]) psw_d[PSW_OV] = i_ov;
      end
      psw_d[PSW_P] = ^acc_d;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc_q <= '0;
         psw_q <= '0;
      end else begin
         acc_q <= acc_d;
         psw_q <= psw_d;
      end
   end

   assign o_acc = acc_q;
   assign o_psw = psw_q;
   assign o_cy  = psw_q[PSW_CY];

endmodule

// File: tb/tb_mc8051_alu_wb.sv
// tb/tb_mc8051_alu_wb.sv - randomized and directed self-checking bench for mc8051_alu_wb
module tb_mc8051_alu_wb;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_alu_vld, i_cy, i_ac, i_ov;
   logic [7:0] i_alu_res, i_dst_addr;
   logic [1:0] i_dst_sel;
   logic [2:0] i_flag_mask;
   logic       i_psw_bit_we, i_psw_bit_val;
   logic [2:0] i_psw_bit_sel;
   logic       i_sfr_psw_we, i_sfr_acc_we;
   logic [7:0] i_sfr_psw_wdata, i_sfr_acc_wdata;
   logic       i_wb_rdy;
   logic       o_alu_rdy, o_wb_vld, o_cy;
   logic [7:0] o_wb_data, o_wb_addr, o_acc, o_psw;
   logic [1:0] o_wb_dst;

   always #5 clk = ~clk;

   mc8051_alu_wb dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_alu_vld(i_alu_vld), .o_alu_rdy(o_alu_rdy),
      .i_alu_res(i_alu_res), .i_dst_sel(i_dst_sel), .i_dst_addr(i_dst_addr),
      .i_cy(i_cy), .i_ac(i_ac), .i_ov(i_ov), .i_flag_mask(i_flag_mask),
      .i_psw_bit_we(i_psw_bit_we), .i_psw_bit_sel(i_psw_bit_sel), .i_psw_bit_val(i_psw_bit_val),
      .i_sfr_psw_we(i_sfr_psw_we), .i_sfr_psw_wdata(i_sfr_psw_wdata),
      .i_sfr_acc_we(i_sfr_acc_we), .i_sfr_acc_wdata(i_sfr_acc_wdata),
      .o_wb_vld(o_wb_vld), .i_wb_rdy(i_wb_rdy),
      .o_wb_data(o_wb_data), .o_wb_dst(o_wb_dst), .o_wb_addr(o_wb_addr),
      .o_acc(o_acc), .o_psw(o_psw), .o_cy(o_cy)
   );

`ifdef MC8051_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
   endtask

   // Reference model: queue of pending memory writes plus architectural ACC and PSW
   typedef struct {
      logic [7:0] d;
      logic [1:0] t;
      logic [7:0] a;
   } ent_t;

   ent_t       mq[$];
   logic [7:0] m_acc = 8'h00;
   logic [7:0] m_psw = 8'h00;
   logic [7:0] wb_log[$];

   bit         e_rdy, e_vld, m_accept, m_byp, m_mem;
   logic [7:0] e_data, e_addr, np;
   logic [1:0] e_dst;
   ent_t       e_new;

   always @(negedge clk) begin
      if (!rst_n) begin
         mq.delete();
         m_acc = 8'h00;
         m_psw = 8'h00;
      end
      e_rdy    = (mq.size() < 2);
      m_accept = rst_n && i_alu_vld && e_rdy;
      m_mem    = (i_dst_sel == 2'b10) || (i_dst_sel == 2'b11);
      m_byp    = BYP && m_accept && m_mem && (mq.size() == 0) && i_wb_rdy;
      e_vld    = (mq.size() > 0) || m_byp;
      e_data = 8'h00; e_dst = 2'b00; e_addr = 8'h00;
      if (mq.size() > 0) begin
         e_data = mq[0].d; e_dst = mq[0].t; e_addr = mq[0].a;
      end else if (m_byp) begin
         e_data = i_alu_res; e_dst = i_dst_sel; e_addr = i_dst_addr;
      end
      chk("alu_rdy", o_alu_rdy, e_rdy);
      chk("wb_vld", o_wb_vld, e_vld);
      chk("wb_data", o_wb_data, e_data);
      chk("wb_dst", o_wb_dst, e_dst);
      chk("wb_addr", o_wb_addr, e_addr);
      chk("acc", o_acc, m_acc);
      chk("psw", o_psw, {m_psw[7:1], ^m_acc});
      chk("cy", o_cy, m_psw[7]);
      if (rst_n) begin
         if (e_vld && i_wb_rdy) begin
            wb_log.push_back(o_wb_addr);
            if (mq.size() > 0) void'(mq.pop_front());
         end
         if (m_accept && m_mem && !m_byp) begin
            e_new.d = i_alu_res; e_new.t = i_dst_sel; e_new.a = i_dst_addr;
            mq.push_back(e_new);
         end
         if (m_accept && i_dst_sel == 2'b01) m_acc = i_alu_res;
         else if (i_sfr_acc_we) m_acc = i_sfr_acc_wdata;
         np = m_psw;
         if (i_sfr_psw_we) np = i_sfr_psw_wdata;
         if (i_psw_bit_we) np[i_psw_bit_sel] = i_psw_bit_val;
         if (m_accept) begin
            if (i_flag_mask[2]) np[7] = i_cy;
            if (i_flag_mask[1]) np[6] = i_ac;
            if (i_flag_mask[0]) np[2] = i_ov;
         end
         m_psw = np;
      end
   end

   task automatic clr();
      i_alu_vld = 0; i_alu_res = 0; i_dst_sel = 0; i_dst_addr = 0;
      i_cy = 0; i_ac = 0; i_ov = 0; i_flag_mask = 0;
      i_psw_bit_we = 0; i_psw_bit_sel = 0; i_psw_bit_val = 0;
      i_sfr_psw_we = 0; i_sfr_psw_wdata = 0; i_sfr_acc_we = 0; i_sfr_acc_wdata = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_addr[3];
   bit         took;

   initial begin
      exp_addr[0] = 8'h30; exp_addr[1] = 8'h31; exp_addr[2] = 8'h32;
      clr();
      i_wb_rdy = 1;
      step(); step();
      chk("rst_acc", o_acc, 8'h00);
      chk("rst_psw", o_psw, 8'h00);
      chk("rst_rdy", o_alu_rdy, 1);
      chk("rst_wb_vld", o_wb_vld, 0);
      rst_n = 1;

      i_sfr_acc_we = 1; i_sfr_acc_wdata = 8'h37;
      step(); clr();
      chk("sfr_acc_parity_acc", o_acc, 8'h37);
      chk("sfr_acc_parity_psw", o_psw, 8'h01);

      i_alu_vld = 1; i_alu_res = 8'h00; i_cy = 1; i_ac = 1; i_ov = 0;
      i_flag_mask = 3'b111; i_dst_sel = 2'b01;
      step(); clr();
      chk("add_acc", o_acc, 8'h00);
      chk("add_psw", o_psw, 8'hC0);
      chk("add_cy", o_cy, 1);

      i_sfr_psw_we = 1; i_sfr_psw_wdata = 8'hFF;
      i_psw_bit_we = 1; i_psw_bit_sel = 3'd7; i_psw_bit_val = 0;
      i_alu_vld = 1; i_flag_mask = 3'b100; i_cy = 0; i_dst_sel = 2'b00;
      step(); clr();
      chk("psw_prio", o_psw, 8'h7E);

      i_sfr_acc_we = 1; i_sfr_acc_wdata = 8'h55;
      i_alu_vld = 1; i_dst_sel = 2'b01; i_alu_res = 8'h0F;
      step(); clr();
      chk("acc_prio", o_acc, 8'h0F);
      chk("acc_prio_psw", o_psw, 8'h7E);

      i_psw_bit_we = 1; i_psw_bit_sel = 3'd0; i_psw_bit_val = 1;
      step(); clr();
      chk("p_bit_ignored", o_psw, 8'h7E);

      i_wb_rdy = 0;
      wb_log.delete();
      i_alu_vld = 1; i_dst_sel = 2'b11; i_dst_addr = 8'h30; i_alu_res = 8'hA0;
      step();
      chk("q1_rdy", o_alu_rdy, 1);
      chk("q1_vld", o_wb_vld, 1);
      i_dst_addr = 8'h31; i_alu_res = 8'hA1;
      step();
      chk("q2_rdy", o_alu_rdy, 0);
      i_dst_addr = 8'h32; i_alu_res = 8'hA2;
      step();
      chk("stall_rdy", o_alu_rdy, 0);
      chk("stall_addr", o_wb_addr, 8'h30);
      chk("stall_data", o_wb_data, 8'hA0);
      i_wb_rdy = 1;
      for (int k = 0; k < 6; k++) begin
         took = o_alu_rdy;
         step();
         if (took) break;
      end
      clr();
      repeat (3) step();
      chk("order_count", wb_log.size(), 3);
      for (int i = 0; i < 3; i++)
         if (i < wb_log.size()) chk("order_addr", wb_log[i], exp_addr[i]);

      i_wb_rdy = 0;
      i_alu_vld = 1; i_dst_sel = 2'b10; i_dst_addr = 8'h40; i_alu_res = 8'h11;
      step();
      i_dst_addr = 8'h41;
      step(); clr();
      chk("pre_rst_vld", o_wb_vld, 1);
      chk("pre_rst_rdy", o_alu_rdy, 0);
      wb_log.delete();
      rst_n = 0;
      #1;
      chk("mid_rst_vld", o_wb_vld, 0);
      chk("mid_rst_rdy", o_alu_rdy, 1);
      chk("mid_rst_data", o_wb_data, 8'h00);
      i_wb_rdy = 1;
      step();
      rst_n = 1;
      repeat (3) step();
      chk("post_rst_pops", wb_log.size(), 0);
      chk("post_rst_vld", o_wb_vld, 0);

      i_wb_rdy = 1;
      i_alu_vld = 1; i_dst_sel = 2'b10; i_alu_res = 8'hA5; i_dst_addr = 8'h07;
      #1;
`ifdef MC8051_WB_BYPASS_EN
      chk("byp_same_vld", o_wb_vld, 1);
      chk("byp_same_data", o_wb_data, 8'hA5);
`else
      chk("nobyp_same_vld", o_wb_vld, 0);
`endif
      step(); clr();
      #1;
`ifdef MC8051_WB_BYPASS_EN
      chk("byp_next_vld", o_wb_vld, 0);
`else
      chk("nobyp_next_vld", o_wb_vld, 1);
      chk("nobyp_next_data", o_wb_data, 8'hA5);
      chk("nobyp_next_dst", o_wb_dst, 2'b10);
`endif

      for (int c = 0; c < 600; c++) begin
         step();
         rst_n           = ($urandom_range(0, 199) != 0);
         i_alu_vld       = $urandom_range(0, 1);
         i_alu_res       = 8'($urandom);
         i_dst_sel       = 2'($urandom);
         i_dst_addr      = 8'($urandom);
         i_cy            = 1'($urandom);
         i_ac            = 1'($urandom);
         i_ov            = 1'($urandom);
         i_flag_mask     = 3'($urandom);
         i_psw_bit_we    = ($urandom_range(0, 3) == 0);
         i_psw_bit_sel   = 3'($urandom);
         i_psw_bit_val   = 1'($urandom);
         i_sfr_psw_we    = ($urandom_range(0, 5) == 0);
         i_sfr_psw_wdata = 8'($urandom);
         i_sfr_acc_we    = ($urandom_range(0, 3) == 0);
         i_sfr_acc_wdata = 8'($urandom);
         i_wb_rdy        = (c % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      end
      step();
      rst_n = 1; clr(); i_wb_rdy = 1;
      repeat (4) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
